// File: rtl/fpcvt_if.sv
// fpcvt data bundle: 13-bit integer sample in, registered S/E/F code out.
// The master drives D; the slave (converter) drives S, E and F.
interface fpcvt_if;
    logic [12:0] D;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;

    modport master (
        output D,
        input  S,
        input  E,
        input  F
    );

    modport slave (
        input  D,
        output S,
        output E,
        output F
    );
endinterface

// File: rtl/fpcvt.sv
// Registered 13-bit two's-complement to 9-bit (S, E[2:0], F[4:0]) float converter.
// Value = (-1)^S * F * 2^E, round half up on the first dropped bit.
module fpcvt (
    input  logic    clk,
    input  logic    rst_n,
    fpcvt_if.slave  io
);
    logic [11:0] mag;
    logic [3:0]  lz;
    logic [5:0]  win;
    logic [4:0]  f0;
    logic        rbit;
    logic [2:0]  e0;
    logic [5:0]  f_inc;
    logic [2:0]  e_n;
    logic [4:0]  f_n;

    logic        s_q;
    logic [2:0]  e_q;
    logic [4:0]  f_q;

    // -4096 has no 12-bit magnitude; clamp it to the largest one
    always_comb begin
        mag = io.D[11:0];
        if (io.D == 13'h1000)
            mag = 12'hFFF;
        else if (io.D[12])
            mag = 12'(~io.D + 13'd1);
    end

    always_comb begin
        lz = 4'd12;
        for (int i = 0; i < 12; i++)
            if (mag[i])
                lz = 4'(11 - i);
    end

    // win holds the 5 significand bits plus the round bit below them
    always_comb begin
        win  = 6'(mag >> (4'd6 - lz));
        e0   = 3'd0;
        f0   = mag[4:0];
        rbit = 1'b0;
        if (lz <= 4'd6) begin
            e0   = 3'(4'd7 - lz);
            f0   = win[5:1];
            rbit = win[0];
        end
    end

    always_comb begin
        f_inc = {1'b0, f0} + {5'd0, rbit};
        e_n   = e0;
        f_n   = f_inc[4:0];
        if (f_inc[5]) begin
            if (e0 == 3'd7) begin
                e_n = 3'd7;
                f_n = 5'd31;
            end else begin
                e_n = e0 + 3'd1;
                f_n = 5'b10000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            e_q <= 3'd0;
            f_q <= 5'd0;
        end else begin
            s_q <= io.D[12];
            e_q <= e_n;
            f_q <= f_n;
        end
    end

    assign io.S = s_q;
    assign io.E = e_q;
    assign io.F = f_q;
endmodule

// File: tb/tb_fpcvt.sv
// Self-checking bench for fpcvt: directed cases, mid-stream reset,
// randomized back-to-back stream and a full input sweep against a reference.
module tb_fpcvt;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fpcvt_if bus ();

    fpcvt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] enc(int s, int e, int f);
        return {1'(s), 3'(e), 5'(f)};
    endfunction

    // Reference: find the exponent that brings the magnitude under 32,
    // round half up by adding half an LSB, then handle carry out.
    function automatic logic [8:0] model(logic [12:0] d);
        int v, mag, e, f, s;
        v   = d[12] ? int'(d) - 8192 : int'(d);
        s   = (v < 0) ? 1 : 0;
        mag = (v < 0) ? -v : v;
        if (mag > 4095) mag = 4095;
        e = 0;
        while ((mag >> e) >= 32) e++;
        f = (e > 0) ? ((mag + (1 << (e - 1))) >> e) : mag;
        if (f == 32) begin
            if (e < 7) begin
                e = e + 1;
                f = 16;
            end else begin
                f = 31;
            end
        end
        return enc(s, e, f);
    endfunction

    task automatic check(string tag, logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.S, bus.E, bus.F};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got S%0d E%0d F%0d (%b), want S%0d E%0d F%0d",
                   tag, obs[8], obs[7:5], obs[4:0], obs,
                   exp[8], exp[7:5], exp[4:0]);
        end
    endtask

    // Drive at the falling edge, check just after the rising edge, then
    // scribble D so only the value present at the edge can matter.
    task automatic step(string tag, logic [12:0] d, logic [8:0] exp);
        @(negedge clk);
        bus.D = d;
        @(posedge clk);
        #1;
        bus.D = 13'($urandom);
        check(tag, exp);
    endtask

    initial begin
        logic [12:0] d;
        bus.D = 13'h0FFF;
        #1 rst_n = 1'b0;
        #1 check("reset_async", enc(0, 0, 0));
        @(posedge clk);
        #1 check("reset_held", enc(0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release", enc(0, 7, 31));

        step("zero",     13'h0000,          enc(0, 0, 0));
        step("minus1",   13'h1FFF,          enc(1, 0, 1));
        step("min4096",  13'h1000,          enc(1, 7, 31));
        step("max4095",  13'h0FFF,          enc(0, 7, 31));
        step("sat4093",  13'b0111111111101, enc(0, 7, 31));
        step("neg422",   13'b1111001011010, enc(1, 4, 26));
        step("v108",     13'b0000001101100, enc(0, 2, 27));
        step("v110",     13'b0000001101110, enc(0, 2, 28));
        step("v111",     13'b0000001101111, enc(0, 2, 28));
        step("ovf253",   13'b0000011111101, enc(0, 4, 16));
        step("ovf1021",  13'b0001111111101, enc(0, 6, 16));
        step("v31",      13'd31,            enc(0, 0, 31));
        step("v32",      13'd32,            enc(0, 1, 16));
        step("v63",      13'd63,            enc(0, 2, 16));
        step("v3968",    13'd3968,          enc(0, 7, 31));
        step("v3967",    13'd3967,          enc(0, 7, 31));
        step("v3903",    13'd3903,          enc(0, 7, 30));

        // Reset mid-stream discards the conversion pending at the next edge
        @(negedge clk);
        bus.D = 13'd108;
        #1 rst_n = 1'b0;
        #1 check("midreset_async", enc(0, 0, 0));
        @(posedge clk);
        #1 check("midreset_discard", enc(0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("midreset_resume", enc(0, 2, 27));

        for (int i = 0; i < 400; i++) begin
            d = 13'($urandom);
            step("rand", d, model(d));
        end

        for (int i = 0; i < 8192; i++) begin
            d = 13'(i);
            step("sweep", d, model(d));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
